// File: rtl/compl_mul_pkg.sv
// Shared widths and helpers for the complex multiplier.
// Defaults plus full-precision width function.
package compl_mul_pkg;

  localparam int DATA_W_DEF = 18;
  localparam int SHIFT_DEF  = 0;

  function automatic int full_w(input int dw);
    return 2 * dw + 1;
  endfunction

  localparam int FULL_W_DEF = 2 * DATA_W_DEF + 1;
  localparam int OUT_W_DEF  = FULL_W_DEF;

endpackage

// File: rtl/compl_mul_rnd_sat.sv
// Round-half-up by SHIFT LSBs, then clip to OUT_W.
// din: IN_W signed; dout: OUT_W signed; clip: value clipped.
module compl_mul_rnd_sat #(
  parameter int IN_W  = 37,
  parameter int OUT_W = 37,
  parameter int SHIFT = 0
) (
  input  logic [IN_W-1:0]  din,
  output logic [OUT_W-1:0] dout,
  output logic             clip
);

  localparam int W = IN_W + 1;

  logic signed [W-1:0] ext;
  logic signed [W-1:0] rnd;

  // one guard bit so the rounding add cannot wrap
  assign ext = W'($signed(din));

  if (SHIFT > 0) begin : g_rnd
    localparam logic signed [W-1:0] HALF =
      {{(W-1){1'b0}}, 1'b1} << (SHIFT - 1);
    assign rnd = (ext + HALF) >>> SHIFT;
  end else begin : g_pass
    assign rnd = ext;
  end

  if (OUT_W < W) begin : g_sat
    localparam logic signed [W-1:0] MAXV =
      {{(W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [W-1:0] MINV = ~MAXV;
    always_comb begin
      clip = 1'b0;
      dout = rnd[OUT_W-1:0];
      if (rnd > MAXV) begin
        clip = 1'b1;
        dout = MAXV[OUT_W-1:0];
      end else if (rnd < MINV) begin
        clip = 1'b1;
        dout = MINV[OUT_W-1:0];
      end
    end
  end else begin : g_ext
    assign dout = OUT_W'(rnd);
    assign clip = 1'b0;
  end

endmodule

// File: rtl/compl_mul_pipe.sv
// 3-stage complex multiplier, a*b or a*conj(b), valid/ready.
// Ports: clk_i, arst_n_i, valid_i/ready_o, a/b/conj in; data/valid_o/ready_i, sat flags out.
module compl_mul_pipe
  import compl_mul_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int OUT_W  = full_w(DATA_W),
  parameter int SHIFT  = SHIFT_DEF
) (
  input  logic              clk_i,
  input  logic              arst_n_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [DATA_W-1:0] data_a_i_i,
  input  logic [DATA_W-1:0] data_a_q_i,
  input  logic [DATA_W-1:0] data_b_i_i,
  input  logic [DATA_W-1:0] data_b_q_i,
  input  logic              conj_i,
  output logic [OUT_W-1:0]  data_i_o,
  output logic [OUT_W-1:0]  data_q_o,
  output logic              valid_o,
  input  logic              ready_i,
  output logic              sat_o,
  output logic              sat_sticky_o,
  input  logic              clr_i
);

  localparam int PW = 2 * DATA_W;
  localparam int FW = full_w(DATA_W);

  logic en;
  logic v1, v2;
  logic c1, c2;
  logic signed [DATA_W-1:0] a_i, a_q, b_i, b_q;
  logic signed [PW-1:0] p_ii, p_qq, p_iq, p_qi;
  logic signed [FW-1:0] e_ii, e_qq, e_iq, e_qi;
  logic signed [FW-1:0] sum_i, sum_q;
  logic [OUT_W-1:0] r_i, r_q;
  logic clip_i, clip_q;
  logic sat_set;

  assign en      = !valid_o || ready_i;
  assign ready_o = en;

  assign e_ii = FW'(p_ii);
  assign e_qq = FW'(p_qq);
  assign e_iq = FW'(p_iq);
  assign e_qi = FW'(p_qi);

  always_comb begin
    sum_i = e_ii - e_qq;
    sum_q = e_iq + e_qi;
    if (c2) begin
      sum_i = e_ii + e_qq;
      sum_q = e_qi - e_iq;
    end
  end

  compl_mul_rnd_sat #(
    .IN_W (FW),
    .OUT_W(OUT_W),
    .SHIFT(SHIFT)
  ) u_rs_i (
    .din (sum_i),
    .dout(r_i),
    .clip(clip_i)
  );

  compl_mul_rnd_sat #(
    .IN_W (FW),
    .OUT_W(OUT_W),
    .SHIFT(SHIFT)
  ) u_rs_q (
    .din (sum_q),
    .dout(r_q),
    .clip(clip_q)
  );

  // sticky rises together with the sat_o word it reports
  assign sat_set = en && v2 && (clip_i || clip_q);

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      v1       <= 1'b0;
      v2       <= 1'b0;
      valid_o  <= 1'b0;
      c1       <= 1'b0;
      c2       <= 1'b0;
      a_i      <= '0;
      a_q      <= '0;
      b_i      <= '0;
      b_q      <= '0;
      p_ii     <= '0;
      p_qq     <= '0;
      p_iq     <= '0;
      p_qi     <= '0;
      data_i_o <= '0;
      data_q_o <= '0;
      sat_o    <= 1'b0;
    end else if (en) begin
      v1       <= valid_i;
      c1       <= conj_i;
      a_i      <= data_a_i_i;
      a_q      <= data_a_q_i;
      b_i      <= data_b_i_i;
      b_q      <= data_b_q_i;
      v2       <= v1;
      c2       <= c1;
      p_ii     <= PW'(a_i) * PW'(b_i);
      p_qq     <= PW'(a_q) * PW'(b_q);
      p_iq     <= PW'(a_i) * PW'(b_q);
      p_qi     <= PW'(a_q) * PW'(b_i);
      valid_o  <= v2;
      data_i_o <= r_i;
      data_q_o <= r_q;
      sat_o    <= v2 && (clip_i || clip_q);
    end
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      sat_sticky_o <= 1'b0;
    end else begin
      sat_sticky_o <= sat_set || (sat_sticky_o && !clr_i);
    end
  end

endmodule

// File: tb/tb_compl_mul_pipe.sv
// Directed bench for compl_mul_pipe.
// Default instance plus an OUT_W=18/SHIFT=17 instance.
module tb_compl_mul_pipe;

  logic clk_i = 1'b0;
  logic arst_n_i;
  logic valid_i, conj_i, ready_i, clr_i;
  logic [17:0] data_a_i_i, data_a_q_i;
  logic [17:0] data_b_i_i, data_b_q_i;

  logic        ready_o, valid_o, sat_o, sat_sticky_o;
  logic [36:0] data_i_o, data_q_o;

  logic        s_ready_o, s_valid_o, s_sat_o, s_sticky_o;
  logic [17:0] s_data_i_o, s_data_q_o;

  int nerr = 0;
  int nchk = 0;

  always #5 clk_i = ~clk_i;

  compl_mul_pipe dut (
    .clk_i       (clk_i),
    .arst_n_i    (arst_n_i),
    .valid_i     (valid_i),
    .ready_o     (ready_o),
    .data_a_i_i  (data_a_i_i),
    .data_a_q_i  (data_a_q_i),
    .data_b_i_i  (data_b_i_i),
    .data_b_q_i  (data_b_q_i),
    .conj_i      (conj_i),
    .data_i_o    (data_i_o),
    .data_q_o    (data_q_o),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .sat_o       (sat_o),
    .sat_sticky_o(sat_sticky_o),
    .clr_i       (clr_i)
  );

  compl_mul_pipe #(
    .DATA_W(18),
    .OUT_W (18),
    .SHIFT (17)
  ) dut_s (
    .clk_i       (clk_i),
    .arst_n_i    (arst_n_i),
    .valid_i     (valid_i),
    .ready_o     (s_ready_o),
    .data_a_i_i  (data_a_i_i),
    .data_a_q_i  (data_a_q_i),
    .data_b_i_i  (data_b_i_i),
    .data_b_q_i  (data_b_q_i),
    .conj_i      (conj_i),
    .data_i_o    (s_data_i_o),
    .data_q_o    (s_data_q_o),
    .valid_o     (s_valid_o),
    .ready_i     (ready_i),
    .sat_o       (s_sat_o),
    .sat_sticky_o(s_sticky_o),
    .clr_i       (clr_i)
  );

  task automatic chk(input string tag,
                     input longint obs,
                     input longint exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic apply(input int ai, input int aq,
                       input int bi, input int bq,
                       input logic cj);
    valid_i    = 1'b1;
    data_a_i_i = 18'(ai);
    data_a_q_i = 18'(aq);
    data_b_i_i = 18'(bi);
    data_b_q_i = 18'(bq);
    conj_i     = cj;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    longint di, dq, si, sq;
    int idx, got, stale;
    arst_n_i = 1'b0;
    valid_i  = 1'b0;
    conj_i   = 1'b0;
    ready_i  = 1'b1;
    clr_i    = 1'b0;
    data_a_i_i = '0;
    data_a_q_i = '0;
    data_b_i_i = '0;
    data_b_q_i = '0;

    #12;
    chk("rst_valid", valid_o, 0);
    chk("rst_ready", ready_o, 1);
    chk("rst_sticky", sat_sticky_o, 0);
    chk("rst_data_i", data_i_o, 0);
    chk("rst_data_q", data_q_o, 0);
    @(negedge clk_i);
    arst_n_i = 1'b1;

    // a*b then a*conj(b), back to back
    @(negedge clk_i);
    apply(3, 4, 5, -2, 1'b0);
    @(negedge clk_i);
    apply(3, 4, 5, -2, 1'b1);
    @(negedge clk_i);
    valid_i = 1'b0;
    chk("lat_early", valid_o, 0);
    @(posedge clk_i); #1;
    di = $signed(data_i_o);
    dq = $signed(data_q_o);
    chk("mul_valid", valid_o, 1);
    chk("mul_i", di, 23);
    chk("mul_q", dq, 14);
    chk("mul_sat", sat_o, 0);
    @(posedge clk_i); #1;
    di = $signed(data_i_o);
    dq = $signed(data_q_o);
    chk("conj_valid", valid_o, 1);
    chk("conj_i", di, 7);
    chk("conj_q", dq, 26);
    @(posedge clk_i); #1;
    chk("drain", valid_o, 0);

    // full-scale negative operands
    @(negedge clk_i);
    apply(-131072, -131072, -131072, -131072, 1'b0);
    @(negedge clk_i);
    valid_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    di = $signed(data_i_o);
    dq = $signed(data_q_o);
    si = $signed(s_data_i_o);
    sq = $signed(s_data_q_o);
    chk("fs_i", di, 0);
    chk("fs_q", dq, 64'sd34359738368);
    chk("fs_sat", sat_o, 0);
    chk("s_valid", s_valid_o, 1);
    chk("s_i", si, 0);
    chk("s_q", sq, 131071);
    chk("s_sat", s_sat_o, 1);
    chk("s_sticky", s_sticky_o, 1);
    @(posedge clk_i); #1;
    chk("s_sat_bubble", s_sat_o, 0);
    chk("s_sticky_hold", s_sticky_o, 1);
    chk("def_sticky", sat_sticky_o, 0);
    @(negedge clk_i);
    clr_i = 1'b1;
    @(negedge clk_i);
    clr_i = 1'b0;
    chk("s_sticky_clr", s_sticky_o, 0);

    // stream of 10 with ready_i low in cycles 4..6
    idx = 0;
    got = 0;
    for (int c = 0; c < 40 && got < 10; c++) begin
      @(negedge clk_i);
      ready_i = !(c >= 4 && c <= 6);
      if (idx < 10) apply(idx + 1, 0, 1, 0, 1'b0);
      else valid_i = 1'b0;
      #1;
      if (c < 10) chk("st_ready", ready_o, !(c >= 4 && c <= 6));
      if (c >= 4 && c <= 6) begin
        di = $signed(data_i_o);
        chk("st_hold_v", valid_o, 1);
        chk("st_hold_d", di, 2);
      end
      if (valid_o && ready_i) begin
        di = $signed(data_i_o);
        chk("st_order", di, got + 1);
        got++;
      end
      if (valid_i && ready_o) idx++;
    end
    chk("st_count", got, 10);
    @(negedge clk_i);
    valid_i = 1'b0;
    chk("st_no_dup", valid_o, 0);

    // reset with samples in flight
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_i);
      apply(100 + k, 0, 1, 0, 1'b0);
    end
    @(negedge clk_i);
    valid_i = 1'b0;
    chk("pre_rst_valid", valid_o, 1);
    #1;
    arst_n_i = 1'b0;
    #1;
    chk("arst_valid", valid_o, 0);
    chk("arst_data", data_i_o, 0);
    chk("arst_ready", ready_o, 1);
    chk("arst_sat", sat_o, 0);
    @(negedge clk_i);
    arst_n_i = 1'b1;
    stale = 0;
    repeat (6) begin
      @(negedge clk_i);
      if (valid_o) stale++;
    end
    chk("no_stale", stale, 0);
    apply(3, 4, 5, -2, 1'b0);
    @(negedge clk_i);
    valid_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    di = $signed(data_i_o);
    dq = $signed(data_q_o);
    chk("post_valid", valid_o, 1);
    chk("post_i", di, 23);
    chk("post_q", dq, 14);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
